display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Parametrised time-multiplexed digit scanner for the board's common-anode seven-segment display. It generalises the fixed 4-digit select mux to N digits and adds an internal refresh prescaler, double-buffered value loading with tear-free frame-boundary swaps, and leading-zero blanking. It sits between the input/data path, which presents packed BCD digits, and the segment decoder, which consumes `digit` and `blank`; `digit_sel` drives the anodes.

## Interface
- `NUM_DIGITS`, default 4: number of display digits, ≥2.
- `DIGIT_W`, default 4: bits per digit code.
- `PRESCALE`, default 100000: clock cycles per digit slot, ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scanning enable.
- `load` in 1: single-cycle strobe that captures `data_in` into the pending buffer.
- `data_in` in NUM_DIGITS*DIGIT_W: packed digits; digit 0 (least significant, rightmost) is in bits [DIGIT_W-1:0].
- `blank_lz` in 1: enables leading-zero blanking.
- `digit` out DIGIT_W: code of the digit currently shown.
- `digit_idx` out clog2(NUM_DIGITS): index of the current slot.
- `digit_sel` out NUM_DIGITS: active-low one-hot anode select.
- `blank` out 1: current slot is blanked.
- `pending` out 1: the pending buffer holds a value not yet displayed.
- `frame_start` out 1: one-cycle pulse when the scan wraps to slot 0.

## Operation
- **Registers**
  - prescale counter `pcnt`, range 0..PRESCALE-1.
  - slot index `idx`.
  - `active` buffer and `pend_buf`, each NUM_DIGITS*DIGIT_W.
  - `pend_valid` flag.
  - registered outputs.
- **Tick:** asserted when `enable`=1 and `pcnt`=PRESCALE-1. `pcnt` then returns to 0; otherwise it increments. With PRESCALE=1, tick is asserted every enabled cycle.
- **Advance:** on tick, `idx` becomes `idx`+1, wrapping NUM_DIGITS-1 → 0.
- **Frame boundary:** the tick on which `idx` wraps to 0.
  - `frame_start` is 1 for that cycle.
  - If `pend_valid`=1: `active` ← `pend_buf` and `pend_valid` ← 0.
- **Load:** `load`=1 sets `pend_buf` ← `data_in` and `pend_valid` ← 1, regardless of `enable`. A later load before the swap overwrites the earlier one (last wins).
- **Load coinciding with a frame-boundary swap:** the swap takes the old `pend_buf`. The new data goes into `pend_buf`, and `pend_valid` stays 1.
- **Blanking:** digit k is blanked iff all of the following hold:
  - `blank_lz`=1;
  - digit k of the value being displayed is zero, along with every digit above k;
  - k≠0 (digit 0 is never blanked).
- **Outputs for the new slot** are computed from the post-swap `active` value.
  - Unblanked slot: `digit` = the digit code; `digit_sel` = all ones except bit `idx`=0; `blank`=0.
  - Blanked slot: `digit`=0, `digit_sel` = all ones, `blank`=1.
- **Disable:** when `enable`=0:
  - `pcnt` ← 0 and `idx` ← NUM_DIGITS-1;
  - `digit_sel` all ones, `digit`=0, `blank`=1, `frame_start`=0;
  - `active` and the pending state are retained.
  - On re-enable, scanning restarts exactly as after reset.

## Timing
- **Reset values:**
  - `pcnt`=0, `idx`=NUM_DIGITS-1, `digit_idx`=NUM_DIGITS-1;
  - `active`=0, `pend_buf`=0, `pending`=0;
  - `digit`=0, `digit_sel`=all ones, `blank`=1, `frame_start`=0.
- **First tick:** occurs PRESCALE cycles after the first enabled cycle, at the edge ending the PRESCALE-th enabled cycle. It wraps to slot 0, so it is a frame boundary.
- **Output latency:** all outputs are registered and update on the clock edge at which the tick is sampled. They hold for exactly PRESCALE cycles per slot, and a frame lasts NUM_DIGITS×PRESCALE cycles.
- **`pending`:** rises on the edge after `load` and falls on the frame-boundary edge that performs the swap.
- **Tear-free updates:** a new value is never shown mid-frame. Slots 1..N-1 always use the same `active` value as slot 0 of that frame.
- **Reset mid-frame:** asynchronous reset returns every register to its reset value immediately, and any pending load is discarded.

## Structure
- A shared package holds the display constants: `SEL_OFF`, the active-low anode polarity, and the default PRESCALE for the 100 MHz board clock.
- A sub-module, `lz_blank_mask`, is natural. It is combinational: it takes the packed value and `blank_lz` and returns a NUM_DIGITS blank mask. The top level instantiates it on the post-swap value.
- The prescaler and the slot index stay in the top level.

## Test plan
- **Basic scan:** NUM_DIGITS=4, PRESCALE=3, reset, `enable`=1, load 0x1234 → `pending` rises, then falls at the first frame start.
  - `digit` sequence 4,3,2,1 repeating, each held 3 cycles.
  - `digit_sel` 1110,1101,1011,0111.
  - `frame_start` every 12 cycles.
- **Leading-zero blanking:** load 0x0050, `blank_lz`=1.
  - Slots 3 and 2 blanked: `digit_sel`=1111, `blank`=1.
  - Slot 1 shows 5; slot 0 shows 0, unblanked.
  - Load 0x0000 → only slot 0 shows.
- **Tear-free update:** load 0xAAAA, then 0x5555 during slot 2 → the rest of the frame shows A; the next frame shows 5. Two loads within a frame → only the last is displayed.
- **Load and swap in the same cycle:** load 0x1111 mid-frame, then load 0x2222 on the frame-boundary cycle.
  - The frame shows 1; `pending` stays 1.
  - The following frame shows 2.
- **Disable and re-enable:** drop `enable` mid-frame → the next edge gives `digit_sel`=1111, `blank`=1, `digit_idx`=3. Re-enable → the first `frame_start` comes after PRESCALE cycles, and `active` is retained.
- **Asynchronous reset and edge case:** assert `rst_n`=0 between clock edges mid-slot → outputs take their reset values without waiting for a clock edge, and `pending`=0. With PRESCALE=1 and NUM_DIGITS=8, the slot advances every cycle.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: anode polarity and board timing constants for the digit scanner
package display_scan_ctrl_pkg;
  localparam logic SEL_ON = 1'b0;
  localparam logic SEL_OFF = 1'b1;
  localparam int DEFAULT_PRESCALE = 100000;
endpackage

// File: rtl/display_scan_ctrl_lz_blank_mask.sv
// lz_blank_mask: marks digits that are zero with all higher digits zero (never digit 0) when blank_lz is set
module lz_blank_mask #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
  input  logic                          blank_lz,
  output logic [NUM_DIGITS-1:0]         mask
);
  always_comb begin
    logic zero_above;
    zero_above = blank_lz;
    mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (value[k*DIGIT_W +: DIGIT_W] == '0);
      mask[k] = zero_above && (k != 0);
    end
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: N-digit scanner with prescaler, frame-synchronous double buffer and leading-zero blanking
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int PRESCALE = DEFAULT_PRESCALE,
  localparam int IW = $clog2(NUM_DIGITS),
  localparam int DW = NUM_DIGITS * DIGIT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [DW-1:0]         data_in,
  input  logic                  blank_lz,
  output logic [DIGIT_W-1:0]    digit,
  output logic [IW-1:0]         digit_idx,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  blank,
  output logic                  pending,
  output logic                  frame_start
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] active_q, active_d, pend_buf_q, pend_buf_d;
  logic pend_valid_q, pend_valid_d;
  logic [DIGIT_W-1:0] digit_q, digit_d, slot_digit;
  logic [NUM_DIGITS-1:0] sel_q, sel_d, slot_sel, mask;
  logic blank_q, blank_d, fs_q, fs_d, tick, wrap, blk;
  always_comb begin
    tick = enable && (pcnt_q == PMAX);
    wrap = tick && (idx_q == IMAX);
    pcnt_d = (tick || !enable) ? '0 : pcnt_q + 1'b1;
    idx_d = !enable ? IMAX : !tick ? idx_q : wrap ? '0 : idx_q + 1'b1;
    active_d = (wrap && pend_valid_q) ? pend_buf_q : active_q;
    pend_buf_d = load ? data_in : pend_buf_q;
    pend_valid_d = load || (pend_valid_q && !wrap);
  end
  lz_blank_mask #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_mask (
    .value(active_d),
    .blank_lz(blank_lz),
    .mask(mask)
  );
  always_comb begin
    slot_sel = {NUM_DIGITS{SEL_OFF}};
    slot_sel[idx_d] = SEL_ON;
    slot_digit = active_d[idx_d*DIGIT_W +: DIGIT_W];
    blk = mask[idx_d];
    digit_d = !enable ? '0 : !tick ? digit_q : blk ? '0 : slot_digit;
    sel_d = !enable ? {NUM_DIGITS{SEL_OFF}} : !tick ? sel_q : blk ? {NUM_DIGITS{SEL_OFF}} : slot_sel;
    blank_d = !enable || (tick ? blk : blank_q);
    fs_d = wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q <= IMAX;
      active_q <= '0;
      pend_buf_q <= '0;
      pend_valid_q <= 1'b0;
      digit_q <= '0;
      sel_q <= {NUM_DIGITS{SEL_OFF}};
      blank_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q <= idx_d;
      active_q <= active_d;
      pend_buf_q <= pend_buf_d;
      pend_valid_q <= pend_valid_d;
      digit_q <= digit_d;
      sel_q <= sel_d;
      blank_q <= blank_d;
      fs_q <= fs_d;
    end
  end
  assign digit = digit_q;
  assign digit_idx = idx_q;
  assign digit_sel = sel_q;
  assign blank = blank_q;
  assign pending = pend_valid_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table-driven and scoreboard checks of the digit scanner in 4-digit and 8-digit builds
module tb_display_scan_ctrl;
  localparam int P = 3;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] digit, digit_sel;
  logic [1:0] digit_idx;
  logic blank, pending, frame_start;
  logic en8 = 1'b0, ld8 = 1'b0;
  logic [31:0] data8 = '0;
  logic [3:0] digit8;
  logic [2:0] idx8;
  logic [7:0] sel8;
  logic blank8, pend8, fs8;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [1:0] idx; logic [3:0] dig; logic [3:0] sel; logic blk;} slot_t;
  typedef struct packed {logic [15:0] value; logic blz; logic [3:0] bmask;} vec_t;
  slot_t q[$];
  vec_t vecs[7];
  always #5 clk = ~clk;
  display_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_W(4), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data_in(data_in), .blank_lz(blank_lz),
    .digit(digit), .digit_idx(digit_idx), .digit_sel(digit_sel), .blank(blank), .pending(pending),
    .frame_start(frame_start)
  );
  display_scan_ctrl #(.NUM_DIGITS(8), .DIGIT_W(4), .PRESCALE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .load(ld8), .data_in(data8), .blank_lz(1'b0),
    .digit(digit8), .digit_idx(idx8), .digit_sel(sel8), .blank(blank8), .pending(pend8),
    .frame_start(fs8)
  );
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    data_in = v;
    step();
    load = 1'b0;
  endtask
  task automatic push_slot(input logic [15:0] v, input logic [3:0] bm, input int s);
    slot_t e;
    e.idx = 2'(s);
    e.blk = bm[s];
    e.dig = e.blk ? 4'h0 : v[s*4 +: 4];
    e.sel = e.blk ? 4'hF : 4'(~(4'b0001 << s));
    q.push_back(e);
  endtask
  task automatic push_frame(input logic [15:0] v, input logic [3:0] bm);
    for (int s = 0; s < 4; s++) push_slot(v, bm, s);
  endtask
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 200);
    if (!frame_start) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_start_timeout: got no pulse expected one within 200 cycles");
    end
  endtask
  task automatic run_slots(input int n);
    slot_t e;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty: got 0 entries expected %0d", n - i);
        return;
      end
      e = q.pop_front();
      chk("slot", {digit_idx, digit, digit_sel, blank}, e);
      repeat (P - 1) step();
      chk("slot_hold", {digit_idx, digit, digit_sel, blank}, e);
      step();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected one");
    $fatal(1);
  end
  initial begin
    int n;
    vecs[0] = '{16'h1234, 1'b0, 4'b0000};
    vecs[1] = '{16'h0050, 1'b1, 4'b1100};
    vecs[2] = '{16'h0000, 1'b1, 4'b1110};
    vecs[3] = '{16'h0000, 1'b0, 4'b0000};
    vecs[4] = '{16'h0103, 1'b1, 4'b1000};
    vecs[5] = '{16'h9000, 1'b1, 4'b0000};
    vecs[6] = '{16'h0809, 1'b1, 4'b1000};
    step();
    chk("reset_outputs", {digit_idx, digit, digit_sel, blank, pending, frame_start}, {2'd3, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0});
    chk("reset_dut8", {idx8, digit8, sel8, blank8, pend8, fs8}, {3'd7, 4'h0, 8'hFF, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    enable = 1'b1;
    foreach (vecs[i]) begin
      blank_lz = vecs[i].blz;
      do_load(vecs[i].value);
      chk("pending_rise", pending, 1'b1);
      push_frame(vecs[i].value, vecs[i].bmask);
      wait_fs(n);
      chk("pending_fall", pending, 1'b0);
      run_slots(4);
    end
    wait_fs(n);
    chk("frame_period", n, 12);
    blank_lz = 1'b0;
    do_load(16'hAAAA);
    push_slot(16'hAAAA, 4'b0, 0);
    push_slot(16'hAAAA, 4'b0, 1);
    push_slot(16'hAAAA, 4'b0, 3);
    push_frame(16'h5555, 4'b0);
    wait_fs(n);
    run_slots(2);
    do_load(16'h5555);
    chk("pending_midframe", pending, 1'b1);
    repeat (P - 1) step();
    run_slots(1);
    chk("new_frame_start", frame_start, 1'b1);
    run_slots(4);
    push_frame(16'h1357, 4'b0);
    do_load(16'h2468);
    step();
    do_load(16'h1357);
    wait_fs(n);
    run_slots(4);
    do_load(16'h1111);
    repeat (4 * P - 2) step();
    chk("last_slot_before_swap", digit_idx, 2'd3);
    do_load(16'h2222);
    chk("coincide_frame_start", frame_start, 1'b1);
    chk("coincide_pending", pending, 1'b1);
    push_frame(16'h1111, 4'b0);
    push_frame(16'h2222, 4'b0);
    run_slots(4);
    chk("coincide_pending_fall", pending, 1'b0);
    run_slots(4);
    step();
    enable = 1'b0;
    step();
    chk("disable_outputs", {digit_idx, digit, digit_sel, blank, frame_start}, {2'd3, 4'h0, 4'hF, 1'b1, 1'b0});
    repeat (5) step();
    chk("disable_hold", {digit_idx, digit_sel, blank}, {2'd3, 4'hF, 1'b1});
    enable = 1'b1;
    wait_fs(n);
    chk("reenable_latency", n, P);
    push_frame(16'h2222, 4'b0);
    run_slots(4);
    do_load(16'h4444);
    chk("pending_before_reset", pending, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {digit_idx, digit, digit_sel, blank, pending, frame_start}, {2'd3, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0});
    step();
    rst_n = 1'b1;
    wait_fs(n);
    chk("post_reset_latency", n, P);
    chk("load_discarded", pending, 1'b0);
    push_frame(16'h0000, 4'b0);
    run_slots(4);
    chk("scoreboard_drained", q.size(), 0);
    data8 = 32'h76543210;
    ld8 = 1'b1;
    en8 = 1'b1;
    step();
    ld8 = 1'b0;
    chk("d8_first_tick_wraps", {fs8, pend8, digit8, idx8}, {1'b1, 1'b1, 4'h0, 3'd0});
    repeat (8) step();
    chk("d8_swap", {fs8, pend8}, {1'b1, 1'b0});
    for (int s = 0; s < 8; s++) begin
      chk("d8_slot", {fs8, idx8, digit8, sel8, blank8}, {s == 0, 3'(s), 4'(s), 8'(~(8'h01 << s)), 1'b0});
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
